// File: rtl/seg_scan_driver.sv
// Time-multiplexed DIGITS x 7-segment scanner with per-digit blink, decimal points and frame snapshot.
// Outputs registered one cycle after idx/snapshot; no backpressure; LEADING_ZERO_BLANK_EN enables leading-zero blanking.
module seg_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 100,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic [4*DIGITS-1:0] num,
  input  logic [DIGITS-1:0]   dp_mask,
  input  logic [DIGITS-1:0]   blink_mask,
  output logic [7:0]          seg,
  output logic [DIGITS-1:0]   anode,
  output logic                frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0]     PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [BW-1:0]     BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [7:0]        SEG_OFF    = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] ANODE_OFF  = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  typedef struct packed {
    logic [4*DIGITS-1:0] num;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blink;
  } snap_t;

  logic [PW-1:0]     pre_cnt;
  logic [IW-1:0]     idx;
  logic [BW-1:0]     blink_cnt;
  logic              blink_hidden;
  snap_t             snap;
  logic              slot_end;
  logic              frame_end;
  logic [DIGITS-1:0] lead_zero;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_blink;
  logic              cur_blank;
  logic [DIGITS-1:0] anode_hot;
  logic [7:0]        seg_hi;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  assign slot_end  = enable && (pre_cnt == PRE_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // All scan state freezes while enable is low so scanning resumes mid-frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_cnt      <= '0;
      idx          <= '0;
      blink_cnt    <= '0;
      blink_hidden <= 1'b0;
      snap         <= '0;
    end else begin
      if (enable) begin
        pre_cnt <= slot_end ? '0 : pre_cnt + 1'b1;
      end
      if (slot_end) begin
        idx <= frame_end ? '0 : idx + 1'b1;
      end
      if (frame_end) begin
        snap.num   <= num;
        snap.dp    <= dp_mask;
        snap.blink <= blink_mask;
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt    <= '0;
          blink_hidden <= ~blink_hidden;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lz_run;

  // lead_zero[i] is indexed by digit position (0 = leftmost); the rightmost digit always shows.
  always_comb begin
    lz_run    = 1'b1;
    lead_zero = '0;
    for (int i = 0; i < DIGITS - 1; i++) begin
      lz_run       = lz_run && (snap.num[4*(DIGITS-1-i) +: 4] == 4'd0);
      lead_zero[i] = lz_run;
    end
  end
`else
  assign lead_zero = '0;
`endif

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_blank = 1'b0;
    anode_hot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib                = snap.num[4*(DIGITS-1-i) +: 4];
        cur_dp                 = snap.dp[DIGITS-1-i];
        cur_blink              = snap.blink[DIGITS-1-i];
        cur_blank              = lead_zero[i];
        anode_hot[DIGITS-1-i]  = 1'b1;
      end
    end
    seg_hi = {cur_dp, seg7(cur_nib)};
    if (cur_blank) begin
      seg_hi[6:0] = '0;
    end
    // Hidden blink phase keeps the anode on but darkens every segment including dp.
    if (blink_hidden && cur_blink) begin
      seg_hi = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seg        <= SEG_OFF;
      anode      <= ANODE_OFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (enable) begin
        seg   <= seg_hi ^ SEG_OFF;
        anode <= anode_hot ^ ANODE_OFF;
      end else begin
        seg   <= SEG_OFF;
        anode <= ANODE_OFF;
      end
    end
  end

endmodule
